picosoc_bus_fabric: RTL and testbench

- Parametrised successor to the hand-written address decode and ready/rdata mux in the SoC top.
- Connects the PicoRV32 native memory port to NSLAVES slave ports.
- Each slave has a programmable base/mask window. Requests and responses are registered, slave accesses are timeout-guarded, and unmapped or stalled accesses are reported through an error interrupt and sticky status.
- Sits between the cpu instance and the RAM/ROM/spimemio/UART/iomem slaves.

---
 rtl/picosoc_defs.sv | 33 +++
 rtl/picosoc_bus_fabric_if.sv | 36 +++
 rtl/picosoc_addr_decode.sv | 31 +++
 rtl/picosoc_bus_fabric.sv | 141 ++++++++++++++
 tb/tb_picosoc_bus_fabric.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/picosoc_defs.sv
// Shared definitions for the PicoSoC bus fabric.
// FSM encodings, error codes and the default memory map.
package picosoc_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNMAPPED = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  localparam int DEF_NSLAVES = 4;

  // slave 3..0: iomem, uart, spimemio, ram
  localparam logic [127:0] DEF_SLV_BASE = {
    32'h0300_0000, 32'h0200_0000,
    32'h0100_0000, 32'h0000_0000
  };
  localparam logic [127:0] DEF_SLV_MASK = {
    32'hFF00_0000, 32'hFFFF_FF00,
    32'hFF00_0000, 32'hFF00_0000
  };

  // width of a slave index; never zero
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/picosoc_bus_fabric_if.sv
// CPU native port plus the shared slave bus.
// slave: fabric view; master: cpu and slaves view.
interface picosoc_bus_fabric_if #(
  parameter int NSLAVES = 4
);
  logic                   mem_valid;
  logic                   mem_ready;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_wdata;
  logic [3:0]             mem_wstrb;
  logic [31:0]            mem_rdata;
  logic [NSLAVES-1:0]     s_valid;
  logic [NSLAVES-1:0]     s_ready;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [3:0]             s_wstrb;
  logic [32*NSLAVES-1:0]  s_rdata;

  modport slave (
    input  mem_valid, mem_addr,
    input  mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output s_valid, s_addr,
    output s_wdata, s_wstrb,
    input  s_ready, s_rdata
  );

  modport master (
    output mem_valid, mem_addr,
    output mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  s_valid, s_addr,
    input  s_wdata, s_wstrb,
    output s_ready, s_rdata
  );
endinterface

// File: rtl/picosoc_addr_decode.sv
// Priority address decoder over base/mask windows.
// Lowest matching slave index wins.
module picosoc_addr_decode
  import picosoc_defs::*;
#(
  parameter int NSLAVES = 4,
  parameter logic [32*NSLAVES-1:0] SLV_BASE =
    DEF_SLV_BASE,
  parameter logic [32*NSLAVES-1:0] SLV_MASK =
    DEF_SLV_MASK,
  localparam int IW = idx_w(NSLAVES)
) (
  input  logic [31:0]   addr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  // scan high to low so the lowest hit lands last
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[32*i +: 32]) ==
          SLV_BASE[32*i +: 32]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/picosoc_bus_fabric.sv
// PicoRV32 memory port to NSLAVES slave fabric.
// Registered request/response, timeout, error status.
module picosoc_bus_fabric
  import picosoc_defs::*;
#(
  parameter int NSLAVES = 4,
  parameter logic [32*NSLAVES-1:0] SLV_BASE =
    DEF_SLV_BASE,
  parameter logic [32*NSLAVES-1:0] SLV_MASK =
    DEF_SLV_MASK,
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  picosoc_bus_fabric_if.slave bus,
  output logic        err_irq,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  localparam int IW = idx_w(NSLAVES);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [NSLAVES-1:0] ONE = 1;

  state_t        state;
  logic [IW-1:0] sel;
  logic [15:0]   cnt;
  logic          dec_hit;
  logic [IW-1:0] dec_idx;
  logic          sel_ready;
  logic [31:0]   sel_rdata;
  logic          err_new;
  logic [1:0]    err_kind;
  logic [31:0]   err_at;

  picosoc_addr_decode #(
    .NSLAVES (NSLAVES),
    .SLV_BASE(SLV_BASE),
    .SLV_MASK(SLV_MASK)
  ) u_dec (
    .addr(bus.mem_addr),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  assign sel_ready = bus.s_ready[sel];
  assign sel_rdata = bus.s_rdata[{sel, 5'd0} +: 32];

  // error detected on the edge that enters RESP
  always_comb begin
    err_new  = 1'b0;
    err_kind = ERR_NONE;
    err_at   = bus.mem_addr;
    if (state == ST_IDLE && bus.mem_valid &&
        !dec_hit) begin
      err_new  = 1'b1;
      err_kind = ERR_UNMAPPED;
    end else if (state == ST_ACCESS &&
                 !sel_ready && cnt == TO_LAST) begin
      err_new  = 1'b1;
      err_kind = ERR_TIMEOUT;
      err_at   = bus.s_addr;
    end
  end

  // request/response FSM with registered bus outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      sel           <= '0;
      cnt           <= '0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      bus.s_valid   <= '0;
      bus.s_addr    <= '0;
      bus.s_wdata   <= '0;
      bus.s_wstrb   <= '0;
    end else begin
      bus.mem_ready <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.mem_valid && dec_hit) begin
            bus.s_addr  <= bus.mem_addr;
            bus.s_wdata <= bus.mem_wdata;
            bus.s_wstrb <= bus.mem_wstrb;
            bus.s_valid <= ONE << dec_idx;
            sel         <= dec_idx;
            cnt         <= '0;
            state       <= ST_ACCESS;
          end else if (bus.mem_valid) begin
            bus.mem_rdata <= ERR_RDATA;
            bus.mem_ready <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_ACCESS: begin
          if (sel_ready) begin
            bus.mem_rdata <= sel_rdata;
            bus.s_valid   <= '0;
            bus.mem_ready <= 1'b1;
            state         <= ST_RESP;
          end else if (cnt == TO_LAST) begin
            bus.mem_rdata <= ERR_RDATA;
            bus.s_valid   <= '0;
            bus.mem_ready <= 1'b1;
            state         <= ST_RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // sticky status; a new error beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_irq  <= 1'b0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end else begin
      err_irq <= err_new;
      if (err_new) begin
        if (err_clr || err_code == ERR_NONE) begin
          err_code <= err_kind;
          err_addr <= err_at;
        end else begin
          err_code <= ERR_OVERFLOW;
        end
      end else if (err_clr) begin
        err_code <= ERR_NONE;
        err_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_picosoc_bus_fabric.sv
// Directed bench for picosoc_bus_fabric.
// Per-slave wait-state responders, TIMEOUT=8.
module tb_picosoc_bus_fabric;

  logic        clk = 1'b0;
  logic        reset;
  logic        err_irq;
  logic [1:0]  err_code;
  logic [31:0] err_addr;
  logic        err_clr;

  picosoc_bus_fabric_if #(.NSLAVES(4)) bus();

  picosoc_bus_fabric #(
    .NSLAVES(4),
    .TIMEOUT(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err_irq (err_irq),
    .err_code(err_code),
    .err_addr(err_addr),
    .err_clr (err_clr)
  );

  always #5 clk = ~clk;

  // slave i answers on access cycle lat_cfg[i]; 0 = never
  int unsigned lat_cfg [4];
  int unsigned act [4];
  logic [31:0] rd_cfg [4];

  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      act[i] <= bus.s_valid[i] ? act[i] + 1 : 0;

  always_comb begin
    bus.s_ready = '0;
    for (int i = 0; i < 4; i++)
      bus.s_ready[i] = bus.s_valid[i] &&
        lat_cfg[i] != 0 && act[i] == lat_cfg[i] - 1;
  end

  always_comb
    bus.s_rdata = {rd_cfg[3], rd_cfg[2],
                   rd_cfg[1], rd_cfg[0]};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  int          r_lat, r_svc;
  logic [3:0]  r_seen, r_sws;
  logic [31:0] r_rd, r_ea, r_swd;
  logic [1:0]  r_code;
  logic        r_irq, r_tail;

  // one cpu transaction; latency counts the request cycle as 1
  task automatic do_req(input logic [31:0] a,
                        input logic [31:0] wd,
                        input logic [3:0]  ws);
    bit done;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    r_lat = 1; r_svc = 0; r_seen = '0;
    r_swd = '0; r_sws = '0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      r_lat++;
      if (bus.s_valid != '0) begin
        r_svc++;
        r_seen |= bus.s_valid;
        r_swd = bus.s_wdata;
        r_sws = bus.s_wstrb;
      end
      if (bus.mem_ready) begin
        done   = 1;
        r_rd   = bus.mem_rdata;
        r_irq  = err_irq;
        r_code = err_code;
        r_ea   = err_addr;
      end
    end
    bus.mem_valid = 1'b0;
    if (!done) chk("req_done", 32'd0, 32'd1);
    @(posedge clk); #1;
    r_tail = bus.mem_ready | err_irq;
  endtask

  task automatic clear_err();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    err_clr = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    lat_cfg = '{1, 1, 1, 1};
    rd_cfg  = '{32'h1234_5678, 32'hB0B0_0001,
                32'hCAFE_0002, 32'hD00D_0003};
    #12;
    chk("rst_ready", 32'(bus.mem_ready), 0);
    chk("rst_rdata", bus.mem_rdata, 0);
    chk("rst_sval", 32'(bus.s_valid), 0);
    chk("rst_saddr", bus.s_addr, 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_eaddr", err_addr, 0);
    chk("rst_irq", 32'(err_irq), 0);
    @(negedge clk); reset = 1'b0;

    // zero-wait read on slave0
    do_req(32'h0000_0010, 32'h0, 4'b0000);
    chk("rd0_lat", r_lat, 3);
    chk("rd0_svc", r_svc, 1);
    chk("rd0_seen", 32'(r_seen), 32'b0001);
    chk("rd0_data", r_rd, 32'h1234_5678);
    chk("rd0_code", 32'(r_code), 0);
    chk("rd0_tail", 32'(r_tail), 0);

    // write on slave2 with 5 wait cycles
    lat_cfg[2] = 5;
    do_req(32'h0200_0008, 32'h41, 4'b0001);
    chk("wr2_lat", r_lat, 7);
    chk("wr2_svc", r_svc, 5);
    chk("wr2_seen", 32'(r_seen), 32'b0100);
    chk("wr2_wdata", r_swd, 32'h41);
    chk("wr2_wstrb", 32'(r_sws), 32'b0001);
    chk("wr2_data", r_rd, 32'hCAFE_0002);
    chk("wr2_tail", 32'(r_tail), 0);

    // outside slave2's narrow window: unmapped
    do_req(32'h0200_0100, 32'h0, 4'b0000);
    chk("um_lat", r_lat, 2);
    chk("um_svc", r_svc, 0);
    chk("um_data", r_rd, 32'hFFFF_FFFF);
    chk("um_irq", 32'(r_irq), 1);
    chk("um_code", 32'(r_code), 1);
    chk("um_eaddr", r_ea, 32'h0200_0100);
    chk("um_tail", 32'(r_tail), 0);
    clear_err();
    #1;
    chk("clr1_code", 32'(err_code), 0);
    chk("clr1_eaddr", err_addr, 0);

    // slave3 never answers: timeout
    lat_cfg[3] = 0;
    do_req(32'h0300_0000, 32'h0, 4'b0000);
    chk("to_lat", r_lat, 10);
    chk("to_svc", r_svc, 8);
    chk("to_seen", 32'(r_seen), 32'b1000);
    chk("to_data", r_rd, 32'hFFFF_FFFF);
    chk("to_irq", 32'(r_irq), 1);
    chk("to_code", 32'(r_code), 2);
    chk("to_eaddr", r_ea, 32'h0300_0000);

    // second error before clear: overflow
    do_req(32'h0500_0000, 32'h0, 4'b0000);
    chk("ov_irq", 32'(r_irq), 1);
    chk("ov_code", 32'(r_code), 3);
    chk("ov_eaddr", r_ea, 32'h0300_0000);
    clear_err();
    #1;
    chk("clr2_code", 32'(err_code), 0);
    chk("clr2_eaddr", err_addr, 0);

    // ready on the last allowed cycle beats timeout
    lat_cfg[3] = 8;
    do_req(32'h0300_0040, 32'h0, 4'b0000);
    chk("edge_lat", r_lat, 10);
    chk("edge_data", r_rd, 32'hD00D_0003);
    chk("edge_irq", 32'(r_irq), 0);
    chk("edge_code", 32'(r_code), 0);

    // async reset in the middle of a slave1 access
    lat_cfg[1] = 0;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0100_0004;
    bus.mem_wstrb = 4'b0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ar_pre_sv", 32'(bus.s_valid), 32'b0010);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ar_sv", 32'(bus.s_valid), 0);
    chk("ar_ready", 32'(bus.mem_ready), 0);
    bus.mem_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    lat_cfg[1] = 2;
    do_req(32'h0100_0000, 32'h0, 4'b0000);
    chk("ar_lat", r_lat, 4);
    chk("ar_data", r_rd, 32'hB0B0_0001);
    chk("ar_code", 32'(r_code), 0);

    // back-to-back slave0 then slave1
    lat_cfg[1] = 1;
    rd_cfg[0] = 32'hA5A5_0000;
    do_req(32'h0000_0100, 32'h0, 4'b0000);
    chk("bb0_lat", r_lat, 3);
    chk("bb0_seen", 32'(r_seen), 32'b0001);
    chk("bb0_data", r_rd, 32'hA5A5_0000);
    do_req(32'h0100_0200, 32'h0, 4'b0000);
    chk("bb1_lat", r_lat, 3);
    chk("bb1_seen", 32'(r_seen), 32'b0010);
    chk("bb1_data", r_rd, 32'hB0B0_0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
